// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; flush empties it and dominates a same-cycle push.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with prefetch FIFO and branch redirect.
// Optional stall_cnt performance counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        should_branch,
    input  logic [31:0] branch_target
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    fetch_state_t state, state_next;
    logic [31:0]  fetch_pc, fetch_pc_next;
    logic [31:0]  req_addr, req_addr_next;
    logic [31:0]  target;
    logic [31:0]  issue_pc;
    logic [63:0]  fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [OW-1:0] occ_after;
    logic         fifo_full, fifo_empty;
    logic         waiting, transfer, redirect, push, space;

    assign waiting  = (state != FETCH_IDLE);
    assign transfer = instr_valid && instr_ready;
    assign redirect = transfer && should_branch;
    assign target   = word_align(branch_target);
    assign push     = (state == FETCH_REQ) && imem_ack && !redirect;
    assign issue_pc = redirect ? target : fetch_pc;

    // Occupancy as it will stand after this edge; the outstanding slot is free
    // whenever this function is consulted (idle, or the request is being acked).
    assign occ_after = redirect ? '0 : (OW'(fifo_count) + OW'(push) - OW'(transfer));
    assign space     = (occ_after < OW'(FIFO_DEPTH));

    // fetch_pc always holds the next address not yet requested, so the
    // DISCARD state can keep imem_addr on the old request while the new
    // target waits here.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_addr_next = req_addr;
        if (waiting && !imem_ack) begin
            if (redirect) begin
                state_next    = FETCH_DISCARD;
                fetch_pc_next = target;
            end
        end else if (space) begin
            state_next    = FETCH_REQ;
            req_addr_next = issue_pc;
            fetch_pc_next = issue_pc + 32'd4;
        end else begin
            state_next    = FETCH_IDLE;
            fetch_pc_next = issue_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_addr <= req_addr_next;
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (transfer),
        .flush (redirect),
        .wdata ({imem_rdata, req_addr}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign imem_req    = waiting;
    assign imem_addr   = req_addr;
    assign instr_valid = !fifo_empty;
    assign instr       = instr_valid ? fifo_rdata[63:32] : '0;
    assign instr_pc    = instr_valid ? fifo_rdata[31:0]  : '0;

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_full && push && !transfer));

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!instr_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus randomized redirect/backpressure traffic.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        should_branch;
    logic [31:0] branch_target;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .should_branch (should_branch),
        .branch_target (branch_target)
`ifdef FETCH_PERF_CNT_EN
       ,.stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Drives one cycle of inputs; a decode transfer about to happen pushes the
    // program-order address the reference model expects to see consumed.
    task automatic drive(input logic ack, input logic rdy, input logic br, input logic [31:0] tgt);
        imem_ack      = ack;
        imem_rdata    = ack ? mem_word(imem_addr) : $urandom();
        instr_ready   = rdy;
        should_branch = br;
        branch_target = tgt;
        if (rst_n && rdy && instr_valid) begin
            exp_q.push_back(model_pc);
            model_pc = br ? {tgt[31:2], 2'b00} : model_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        exp_q.delete();
        model_pc = RST_PC;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: pops on every decode transfer and checks the instruction.
    logic gap_pending = 1'b0;
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            gap_pending = 1'b0;
        end else begin
            if (gap_pending) chk("gap_after_redirect", {31'b0, instr_valid}, 32'h0);
            gap_pending = 1'b0;
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", instr_pc, e);
                    chk("sb_instr", instr, mem_word(e));
                end
                gap_pending = should_branch;
            end
        end
    end

    // Memory-handshake protocol monitor.
    logic        p_valid = 1'b0;
    logic        p_req, p_ack;
    logic [31:0] p_addr;
    always @(negedge clk) begin
        if (rst_n && p_valid && p_req && !p_ack) begin
            chk("req_hold", {31'b0, imem_req}, 32'h1);
            chk("addr_hold", imem_addr, p_addr);
        end
        if (rst_n && imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        p_valid = rst_n;
        p_req   = imem_req;
        p_ack   = imem_ack;
        p_addr  = imem_addr;
    end

    task automatic run_random(input int n, input int ack_pct, input int rdy_pct, input int br_pct);
        logic        a, r, b;
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(99) < ack_pct);
            r = ($urandom_range(99) < rdy_pct);
            b = ($urandom_range(99) < br_pct);
            t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
            drive(a, r, b, t);
            tick();
        end
    endtask

    initial begin
        int accepted;
        rst_n = 1'b0;
        model_pc = RST_PC;

        // Streaming: ack every cycle, decode always ready.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'hBFC0_0000);
        chk("first_valid_early", {31'b0, instr_valid}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("first_valid", {31'b0, instr_valid}, 32'h1);
        chk("first_pc", instr_pc, 32'hBFC0_0000);
        chk("second_addr", imem_addr, 32'hBFC0_0004);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("second_pc", instr_pc, 32'hBFC0_0004);
        chk("third_addr", imem_addr, 32'hBFC0_0008);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("third_pc", instr_pc, 32'hBFC0_0008);

        // Backpressure: FIFO fills to depth, acks while idle are ignored.
        do_reset();
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            if (imem_req) accepted++;
            tick();
        end
        chk("fill_count", 32'(accepted), 32'd4);
        chk("req_while_full", {31'b0, imem_req}, 32'h0);
        chk("full_head_pc", instr_pc, 32'hBFC0_0000);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            tick();
        end

        // Slow memory: request held stable while ack is withheld.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("slow_req0", {31'b0, imem_req}, 32'h1);
        chk("slow_addr0", imem_addr, 32'hBFC0_0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            tick();
            chk("slow_req", {31'b0, imem_req}, 32'h1);
            chk("slow_addr", imem_addr, 32'hBFC0_0000);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("slow_valid", {31'b0, instr_valid}, 32'h1);
        chk("slow_pc", instr_pc, 32'hBFC0_0000);

        // Redirect while a request is outstanding.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("disc_setup", imem_addr, 32'hBFC0_0004);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        tick();
        chk("disc_req", {31'b0, imem_req}, 32'h1);
        chk("disc_addr", imem_addr, 32'hBFC0_0004);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("disc_addr2", imem_addr, 32'hBFC0_0004);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("disc_new_addr", imem_addr, 32'h0000_0100);
        chk("disc_no_valid", {31'b0, instr_valid}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("disc_new_pc", instr_pc, 32'h0000_0100);

        // Redirect coincident with an ack: acked word never reaches decode.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0008);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("coin_setup_addr", imem_addr, 32'h0000_0010);
        chk("coin_setup_pc", instr_pc, 32'h0000_0008);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        tick();
        chk("coin_empty", {31'b0, instr_valid}, 32'h0);
        chk("coin_addr", imem_addr, 32'h0000_0200);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("coin_pc", instr_pc, 32'h0000_0200);

`ifdef FETCH_PERF_CNT_EN
        // Stall counter: 1 fill edge + 10 withheld cycles + 1 acking edge.
        do_reset();
        chk("stall_rst", stall_cnt, 32'd0);
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        chk("stall_valid", {31'b0, instr_valid}, 32'h1);
        chk("stall_cnt", stall_cnt, 32'd12);
`endif

        // Randomized traffic, resets landing mid-transaction between segments.
        do_reset();
        run_random(1000, 60, 70, 10);
        do_reset();
        run_random(1000, 80, 20, 5);
        do_reset();
        run_random(1000, 40, 90, 20);

        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4: prefetch buffer entries; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_ack  input  1  request accepted; read data valid this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-009 instr  output  32  instruction presented to decode.
REQ-010 instr_pc  output  32  address of instr.
REQ-011 instr_valid  output  1  instr/instr_pc valid.
REQ-012 instr_ready  input  1  decode consumes instr this cycle when instr_valid=1.
REQ-013 should_branch  input  1  decode redirect request for the presented instr.
REQ-014 branch_target  input  32  redirect address; bits [1:0] ignored, treated as 0.

Function
REQ-015 Memory handshake: at most one outstanding request; imem_req and imem_addr held stable from assertion until the cycle imem_ack=1.
REQ-016 New request issued only when FIFO occupancy plus outstanding count < FIFO_DEPTH.
REQ-017 On imem_ack with no pending discard: {imem_rdata, imem_addr} written to FIFO at that edge; fetch PC advances by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0); imem_req may re-assert the next cycle.
REQ-018 Latency: instr_valid rises the cycle after the acking cycle when FIFO was empty; no combinational path imem_rdata -> instr.
REQ-019 Decode transfer: FIFO pops at edge with instr_valid && instr_ready; simultaneous push and pop legal at full or empty.
REQ-020 Redirect fires at edge with instr_valid && instr_ready && should_branch: FIFO flushed, fetch PC <= branch_target, no delay slot; should_branch ignored otherwise.
REQ-021 Redirect with request outstanding and no ack same cycle: state DISCARD; req stays asserted at old address; response dropped on ack; then fetch from branch_target.
REQ-022 Redirect in same cycle as imem_ack: acked data dropped; next request to branch_target.
REQ-023 FSM states: IDLE (no request), REQ (waiting ack), DISCARD (waiting ack, drop data). IDLE->REQ on space; REQ->IDLE or REQ on ack; REQ->DISCARD on redirect without ack; DISCARD->REQ/IDLE on ack.
REQ-024 instr_valid=0 during the cycle after a redirect regardless of prior FIFO contents.

Reset
REQ-025 While rst_n=0: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, FIFO empty, FSM IDLE, fetch PC=RESET_PC.
REQ-026 First imem_req=1 in first clock edge after rst_n deasserts; reset mid-transaction abandons it; a late imem_ack while IDLE is ignored.

Configuration
REQ-027 Macro FETCH_PERF_CNT_EN defined: output stall_cnt [31:0] counts cycles with rst_n=1 and instr_valid=0, saturating at 32'hFFFF_FFFF, reset to 0.
REQ-028 Macro FETCH_PERF_CNT_EN undefined: port stall_cnt and counter absent; all other behaviour identical.

Structure
REQ-029 Package constants holds the fetch FSM state enum (FETCH_IDLE, FETCH_REQ, FETCH_DISCARD) and RESET_PC default constant.
REQ-030 Sub-module fetch_fifo: synchronous FIFO, parameters WIDTH=64, DEPTH; ports push, pop, flush, full, empty, count; flush dominates push.

Verification
REQ-031 Reset release, imem_ack=1 every cycle, instr_ready=1 -> addresses BFC00000, BFC00004, BFC00008 in order; first instr_valid 2 cycles after reset release.
REQ-032 instr_ready=0 for 20 cycles, ack always 1 -> exactly FIFO_DEPTH=4 words buffered, imem_req=0 while full, no data loss on release.
REQ-033 imem_ack delayed 3 cycles -> imem_addr and imem_req stable all 3 cycles.
REQ-034 should_branch with target 0000_0100 while ack pending -> pending response discarded, next imem_addr 0000_0100, next instr_pc 0000_0100.
REQ-035 Redirect to 0000_0200 coincident with ack of 0000_0010 -> 0000_0010 never presented; FIFO empty next cycle.
REQ-036 With FETCH_PERF_CNT_EN, ack withheld 10 cycles after reset -> stall_cnt = 10 (plus fill latency) before first instr_valid.
